// File: rtl/ask_demod_10.sv
// ASK demodulator: integrates |sample-512| over SYM_LEN samples and slices each symbol against a threshold.
// Optional feature: define ASK_DEMOD_HYST_EN for a hysteresis threshold driven by the previous decision.
module ask_demod_10 #(
    parameter int SYM_LEN = 64,
    parameter int NUM_SYM = 32
`ifdef ASK_DEMOD_HYST_EN
    ,
    parameter int HYST    = 256
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_en,
    input  logic [9:0]  data_in,
    input  logic [17:0] thresh,
    output logic        bit_out,
    output logic        bit_valid,
    output logic [17:0] level_out,
    output logic        busy,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(SYM_LEN);
    localparam int SYM_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NUM_SYM - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic              en_q;
    logic [17:0]       acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SYM_W-1:0]  sym_q;
    logic              bit_q;
    logic              valid_q;
    logic [17:0]       level_q;
    logic              busy_q;
    logic              done_q;

    logic [9:0]        mag_d;
    logic [17:0]       sum_d;
    logic [17:0]       thr_d;
    logic              dec_d;

    // Offset-binary to magnitude; 0 maps to 512, so the result still fits 10 bits.
    function automatic logic [9:0] sample_mag(input logic [9:0] s);
        if (s[9])
            return {1'b0, s[8:0]};
        else
            return 10'd512 - s;
    endfunction

`ifdef ASK_DEMOD_HYST_EN
    logic prev_q;

    function automatic logic [17:0] hyst_thresh(input logic [17:0] t, input logic prev);
        logic [18:0] up;
        up = {1'b0, t} + 19'(HYST);
        if (prev)
            return (t >= 18'(HYST)) ? (t - 18'(HYST)) : 18'd0;
        else
            return up[18] ? 18'h3FFFF : up[17:0];
    endfunction

    assign thr_d = hyst_thresh(thresh, prev_q);
`else
    assign thr_d = thresh;
`endif

    assign mag_d = sample_mag(data_in);
    assign sum_d = acc_q + 18'(mag_d);
    assign dec_d = (sum_d >= thr_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sym_q   <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            level_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ASK_DEMOD_HYST_EN
            prev_q  <= 1'b0;
`endif
        end else begin
            en_q    <= enable;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && !en_q) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sym_q   <= '0;
`ifdef ASK_DEMOD_HYST_EN
                        prev_q  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    // A low enable wins over a symbol-completing sample: the frame is dropped silently.
                    if (!enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sym_q   <= '0;
                    end else if (sample_en) begin
                        if (cnt_q == CNT_LAST) begin
                            level_q <= sum_d;
                            bit_q   <= dec_d;
                            valid_q <= 1'b1;
                            acc_q   <= '0;
                            cnt_q   <= '0;
`ifdef ASK_DEMOD_HYST_EN
                            prev_q  <= dec_d;
`endif
                            if (sym_q == SYM_LAST) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                sym_q   <= '0;
                            end else begin
                                sym_q   <= sym_q + 1'b1;
                            end
                        end else begin
                            acc_q <= sum_d;
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bit_out    = bit_q;
    assign bit_valid  = valid_q;
    assign level_out  = level_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ask_demod_10.sv
// Scoreboard bench for ask_demod_10: a behavioural model queues expected symbols, a monitor pops them on bit_valid.
module tb_ask_demod_10;

    localparam int SL = 4;
    localparam int NS = 4;
    localparam int TH = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        sample_en = 1'b0;
    logic [9:0]  data_in = 10'd512;
    logic [17:0] thresh = 18'(TH);
    logic        bit_out, bit_valid, busy, frame_done;
    logic [17:0] level_out;

    logic        enable_b = 1'b0;
    logic        sample_en_b = 1'b0;
    logic        bit_out_b, bit_valid_b, busy_b, frame_done_b;
    logic [17:0] level_out_b;

    ask_demod_10 #(.SYM_LEN(SL), .NUM_SYM(NS)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_en(sample_en),
        .data_in(data_in), .thresh(thresh), .bit_out(bit_out), .bit_valid(bit_valid),
        .level_out(level_out), .busy(busy), .frame_done(frame_done)
    );

    ask_demod_10 #(.SYM_LEN(2), .NUM_SYM(3)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .sample_en(sample_en_b),
        .data_in(data_in), .thresh(thresh), .bit_out(bit_out_b), .bit_valid(bit_valid_b),
        .level_out(level_out_b), .busy(busy_b), .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int level;
        int b;
        int cyc;
    } exp_t;
    exp_t sb[$];

    bit m_run = 1'b0;
    bit m_prev = 1'b0;
    int macc = 0;
    int mcnt = 0;
    int msym = 0;

    function automatic int mag(input int d);
        return (d >= 512) ? d - 512 : 512 - d;
    endfunction

    task automatic model_clear();
        macc = 0; mcnt = 0; msym = 0; m_prev = 1'b0;
    endtask

    task automatic model_step(input int d);
        int thr;
        exp_t e;
        if (!m_run) return;
        macc += mag(d);
        mcnt++;
        if (mcnt == SL) begin
            thr = TH;
`ifdef ASK_DEMOD_HYST_EN
            thr = m_prev ? ((TH >= 256) ? TH - 256 : 0) : ((TH + 256 > 262143) ? 262143 : TH + 256);
`endif
            e.level = macc;
            e.b = (macc >= thr) ? 1 : 0;
            e.cyc = cyc + 1;
            sb.push_back(e);
            m_prev = e.b[0];
            macc = 0;
            mcnt = 0;
            msym++;
            if (msym == NS) m_run = 1'b0;
        end
    endtask

    task automatic send(input int d);
        @(negedge clk);
        sample_en = 1'b1;
        data_in = 10'(d);
        model_step(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_en = 1'b0;
        end
    endtask

    task automatic arm();
        @(negedge clk);
        enable = 1'b1;
        sample_en = 1'b0;
        model_clear();
        m_run = 1'b1;
    endtask

    task automatic drop();
        @(negedge clk);
        enable = 1'b0;
        sample_en = 1'b0;
        m_run = 1'b0;
        model_clear();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (bit_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_bit_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("level_out", int'(level_out), e.level);
                chk("bit_out", int'(bit_out), e.b);
                chk("valid_cycle", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
            e = sb.pop_front();
            chk("missing_bit_valid", cyc, e.cyc - 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_chk, n_err);
        $fatal(1);
    end

    initial begin
        int pat[10] = '{1, 1, 5, 1, 5, 1, 6, 0, 0, 0};
        int got;
        #1 reset = 1'b1;
        enable = 1'b1;
        #1;
        chk("rst_bit_out", int'(bit_out), 0);
        chk("rst_bit_valid", int'(bit_valid), 0);
        chk("rst_level_out", int'(level_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        idle(2);
        // Release with enable already high: the first edge must start a frame.
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        m_run = 1'b1;
        @(negedge clk);
        chk("busy_after_release", int'(busy), 1);

        repeat (4) send(512);
        send(1023); send(0); send(1023); send(0);
        repeat (4) begin
            send(int'($urandom_range(0, 1023)));
            idle(int'($urandom_range(0, 2)));
        end
        repeat (4) send(int'($urandom_range(0, 1023)));
        @(negedge clk);
        chk("frame_done_hi", int'(frame_done), 1);
        chk("busy_in_done", int'(busy), 0);
        sample_en = 1'b1;
        data_in = 10'd1023;
        repeat (5) begin
            @(negedge clk);
            chk("busy_no_rearm", int'(busy), 0);
            chk("frame_done_lo", int'(frame_done), 0);
        end

        drop(); idle(1); arm();
        send(1023); send(1023);
        drop(); idle(1); arm();
        repeat (4) send(1023);
        send(1023); send(1023);
        @(negedge clk);
        sample_en = 1'b0;
        chk("busy_mid_symbol", int'(busy), 1);
        #1 reset = 1'b1;
        m_run = 1'b0;
        model_clear();
        #1;
        chk("async_rst_bit_out", int'(bit_out), 0);
        chk("async_rst_level_out", int'(level_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_bit_valid", int'(bit_valid), 0);
        chk("async_rst_frame_done", int'(frame_done), 0);
        idle(2);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        m_run = 1'b1;

        repeat (4) send(787);
        send(837); send(187); send(837); send(187);
        repeat (4) send(712);
        send(337); send(687); send(337); send(687);
        @(negedge clk);
        sample_en = 1'b0;
        chk("frame_done_frame2", int'(frame_done), 1);
        idle(3);
        chk("scoreboard_empty", sb.size(), 0);

        data_in = 10'd1023;
        @(negedge clk);
        enable_b = 1'b1;
        sample_en_b = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            got = {29'd0, bit_valid_b, frame_done_b, busy_b};
            chk($sformatf("frame3x2_cycle%0d", n + 1), got, pat[n]);
            if (bit_valid_b === 1'b1) chk("frame3x2_level", int'(level_out_b), 1022);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
